// File: rtl/st2mm_tx_arbiter_if.sv
// AXI-Stream bundle shared by the ST2MM TX arbiter sources and its output.
//   tvalid/tready : handshake
//   tdata         : payload, TDATA_WIDTH bits
//   tkeep         : byte enables, TDATA_WIDTH/8 bits
//   tlast         : end of packet
//   tuser         : tuser_vendor sideband, TUSER_WIDTH bits
// Modports: master drives the stream, slave drives tready.
interface st2mm_tx_arbiter_if #(
    parameter int unsigned TDATA_WIDTH = 512,
    parameter int unsigned TUSER_WIDTH = 10
);
    logic                     tvalid;
    logic                     tready;
    logic [TDATA_WIDTH-1:0]   tdata;
    logic [TDATA_WIDTH/8-1:0] tkeep;
    logic                     tlast;
    logic [TUSER_WIDTH-1:0]   tuser;

    modport master (output tvalid, output tdata, output tkeep, output tlast,
                    output tuser, input tready);
    modport slave  (input tvalid, input tdata, input tkeep, input tlast,
                    input tuser, output tready);
endinterface

// File: rtl/st2mm_tx_arbiter.sv
// Packet-level 2:1 arbiter merging the MMIO completion stream (s0) and the
// VDM/MCTP TX stream (s1) onto the single ST2MM TX AXI-S. Whole packets are
// granted (SOP..TLAST, never interleaved) through one registered output stage.
//
// Ports:
//   clk, rst_n      clock; synchronous active-low reset
//   s0              slave stream, src 0 (MMIO completions)
//   s1              slave stream, src 1 (VDM TX)
//   m               master stream toward the PCIe SS
//   gnt             one-hot current grant {s1,s0}; 2'b00 when idle
//   pkt_cnt0/1      per-source forwarded packet counters (wrap, no saturation)
//
// Build option: define ST2MM_TX_ARB_S0_PRIO_EN for strict priority to s0;
// otherwise sources are served round-robin.
module st2mm_tx_arbiter #(
    parameter int unsigned TDATA_WIDTH = 512,
    parameter int unsigned TUSER_WIDTH = 10,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    st2mm_tx_arbiter_if.slave    s0,
    st2mm_tx_arbiter_if.slave    s1,
    st2mm_tx_arbiter_if.master   m,
    output logic [1:0]           gnt,
    output logic [CNT_WIDTH-1:0] pkt_cnt0,
    output logic [CNT_WIDTH-1:0] pkt_cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   last_gnt, last_gnt_nxt;   // 0 = s0 served last, 1 = s1

    logic   out_en;
    logic   acc0, acc1;
    logic   eop0, eop1;

    logic                     m_tvalid_q;
    logic [TDATA_WIDTH-1:0]   m_tdata_q;
    logic [TDATA_WIDTH/8-1:0] m_tkeep_q;
    logic                     m_tlast_q;
    logic [TUSER_WIDTH-1:0]   m_tuser_q;

    // Output register may load whenever it is empty or being drained.
    always_comb begin
        out_en    = ~m_tvalid_q | m.tready;
        s0.tready = (state == GNT0) & out_en;
        s1.tready = (state == GNT1) & out_en;
        acc0      = s0.tvalid & s0.tready;
        acc1      = s1.tvalid & s1.tready;
        eop0      = acc0 & s0.tlast;
        eop1      = acc1 & s1.tlast;
    end

    always_comb begin
        case (state)
            GNT0:    gnt = 2'b01;
            GNT1:    gnt = 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        last_gnt_nxt = last_gnt;
        case (state)
            IDLE: begin
`ifdef ST2MM_TX_ARB_S0_PRIO_EN
                if (s0.tvalid)      state_nxt = GNT0;
                else if (s1.tvalid) state_nxt = GNT1;
`else
                if (s0.tvalid && s1.tvalid) state_nxt = last_gnt ? GNT0 : GNT1;
                else if (s0.tvalid)         state_nxt = GNT0;
                else if (s1.tvalid)         state_nxt = GNT1;
`endif
            end
            GNT0: begin
                if (eop0) begin
                    last_gnt_nxt = 1'b0;
`ifdef ST2MM_TX_ARB_S0_PRIO_EN
                    // s0 is necessarily valid on its own tlast beat, so it
                    // keeps priority: re-arbitrate from IDLE (one bubble).
                    state_nxt = IDLE;
`else
                    state_nxt = s1.tvalid ? GNT1 : IDLE;
`endif
                end
            end
            GNT1: begin
                if (eop1) begin
                    last_gnt_nxt = 1'b1;
                    state_nxt    = s0.tvalid ? GNT0 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_tvalid_q <= 1'b0;
        end else if (out_en) begin
            m_tvalid_q <= acc0 | acc1;
        end
    end

    // Payload is don't-care while m_tvalid is low, so it carries no reset.
    always_ff @(posedge clk) begin
        if (acc0) begin
            m_tdata_q <= s0.tdata;
            m_tkeep_q <= s0.tkeep;
            m_tlast_q <= s0.tlast;
            m_tuser_q <= s0.tuser;
        end else if (acc1) begin
            m_tdata_q <= s1.tdata;
            m_tkeep_q <= s1.tkeep;
            m_tlast_q <= s1.tlast;
            m_tuser_q <= s1.tuser;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else begin
            if (eop0) pkt_cnt0 <= pkt_cnt0 + CNT_WIDTH'(1);
            if (eop1) pkt_cnt1 <= pkt_cnt1 + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        m.tvalid = m_tvalid_q;
        m.tdata  = m_tdata_q;
        m.tkeep  = m_tkeep_q;
        m.tlast  = m_tlast_q;
        m.tuser  = m_tuser_q;
    end

endmodule

// File: tb/tb_st2mm_tx_arbiter.sv
// Self-checking bench for st2mm_tx_arbiter: per-source beat queues feed
// drivers, expected beats go to a scoreboard queue in predicted grant order,
// and a monitor pops/compares every beat handed off on the output stream.
module tb_st2mm_tx_arbiter;

    localparam int unsigned DW = 64;
    localparam int unsigned KW = DW / 8;
    localparam int unsigned UW = 10;
    localparam int unsigned CW = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [UW-1:0] user;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    gnt;
    logic [CW-1:0] pkt_cnt0, pkt_cnt1;

    st2mm_tx_arbiter_if #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) s0_if ();
    st2mm_tx_arbiter_if #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) s1_if ();
    st2mm_tx_arbiter_if #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) m_if ();

    st2mm_tx_arbiter #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .CNT_WIDTH(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s0       (s0_if),
        .s1       (s1_if),
        .m        (m_if),
        .gnt      (gnt),
        .pkt_cnt0 (pkt_cnt0),
        .pkt_cnt1 (pkt_cnt1)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    failures = 0;
    beat_t q0[$];
    beat_t q1[$];
    beat_t exp_q[$];
    int    pid_n = 0;
    int    exp_cnt0 = 0;
    int    exp_cnt1 = 0;

    function automatic beat_t make_beat(input int src, input int pid, input int idx, input bit last);
        beat_t b;
        logic [31:0] s;
        s      = 32'(src);
        b.data = {8'(src), 16'(pid), 8'(idx), 32'hC0DE_0000 ^ 32'(pid * 7 + idx)};
        b.keep = last ? 8'h0F : 8'hFF;
        b.last = last;
        b.user = {s[0], 9'(pid)};
        return b;
    endfunction

    task automatic push_pkt(input int src, input int nbeats);
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            b = make_beat(src, pid_n, i, i == nbeats - 1);
            if (src == 0) q0.push_back(b);
            else          q1.push_back(b);
            exp_q.push_back(b);
        end
        if (src == 0) exp_cnt0++;
        else          exp_cnt1++;
        pid_n++;
    endtask

    // Source drivers: present the queue head every cycle, retire it on handshake.
    initial begin
        s0_if.tvalid = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (q0.size() > 0) begin
                s0_if.tvalid = 1'b1;
                {s0_if.tdata, s0_if.tkeep, s0_if.tlast, s0_if.tuser} = q0[0];
            end else begin
                s0_if.tvalid = 1'b0;
            end
            @(negedge clk);
            if (s0_if.tvalid && s0_if.tready && q0.size() > 0) void'(q0.pop_front());
        end
    end

    initial begin
        s1_if.tvalid = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (q1.size() > 0) begin
                s1_if.tvalid = 1'b1;
                {s1_if.tdata, s1_if.tkeep, s1_if.tlast, s1_if.tuser} = q1[0];
            end else begin
                s1_if.tvalid = 1'b0;
            end
            @(negedge clk);
            if (s1_if.tvalid && s1_if.tready && q1.size() > 0) void'(q1.pop_front());
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        beat_t got, want;
        if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
            got = {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got=%h want=<none>", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    failures++;
                    $display("FAIL sb_beat got=%h want=%h", got, want);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        m_if.tready = 1'b1;
        q0.delete();
        q1.delete();
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_if.tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({m_if.tvalid, gnt, s0_if.tready, s1_if.tready} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=00000",
                     {m_if.tvalid, gnt, s0_if.tready, s1_if.tready});
        end
        checks++;
        if ({pkt_cnt0, pkt_cnt1} !== '0) begin
            failures++;
            $display("FAIL reset_cnt got=%h/%h want=0/0", pkt_cnt0, pkt_cnt1);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_src();
        bit [5:0]  exp_v = 6'b001110;
        bit [11:0] exp_g = {2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
        bit        ok;
        @(negedge clk); #1;
        push_pkt(0, 3);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if ({m_if.tvalid, gnt} !== {exp_v[5-k], exp_g[(5-k)*2 +: 2]}) begin
                failures++;
                $display("FAIL single_timing cyc=%0d got=%b want=%b", k,
                         {m_if.tvalid, gnt}, {exp_v[5-k], exp_g[(5-k)*2 +: 2]});
            end
            if (k == 4) begin
                checks++;
                if (m_if.tlast !== 1'b1) begin
                    failures++;
                    $display("FAIL single_tlast got=%b want=1", m_if.tlast);
                end
            end
        end
        drain(20, ok);
        checks++;
        if (!ok || pkt_cnt0 !== 8'd1) begin
            failures++;
            $display("FAIL single_cnt got=%0d drained=%0d want=1/1", pkt_cnt0, ok);
        end
    endtask

    task automatic test_tie();
        logic [6:0] obs;
`ifdef ST2MM_TX_ARB_S0_PRIO_EN
        logic [6:0] want = 7'b0011011;
        int         starve = 0;
`else
        logic [6:0] want = 7'b0011110;
`endif
        bit         ok;
        do_reset();
        @(negedge clk); #1;
        push_pkt(0, 2);
        push_pkt(1, 2);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            obs[6-k] = m_if.tvalid;
        end
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL tie_bubbles got=%b want=%b", obs, want);
        end
        drain(30, ok);
        checks++;
        if (!ok || pkt_cnt0 !== 8'd1 || pkt_cnt1 !== 8'd1) begin
            failures++;
            $display("FAIL tie_cnt got=%0d/%0d drained=%0d want=1/1/1", pkt_cnt0, pkt_cnt1, ok);
        end
`ifdef ST2MM_TX_ARB_S0_PRIO_EN
        push_pkt(0, 2);
        push_pkt(0, 2);
        push_pkt(0, 2);
        push_pkt(1, 1);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (q0.size() == 0) break;
            if (gnt === 2'b10) starve++;
        end
        checks++;
        if (starve != 0) begin
            failures++;
            $display("FAIL prio_starve got=%0d want=0", starve);
        end
        drain(30, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL prio_drain got=timeout want=drained");
        end
`endif
    endtask

    task automatic test_stall();
        bit [6:0] pat = 7'b1001101;
        beat_t    snap, cur;
        bit       stalled = 1'b0;
        bit       ok;
        @(negedge clk); #1;
        push_pkt(1, 4);
        @(negedge clk); #1;
        push_pkt(0, 1);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_if.tvalid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL stall_start got=timeout want=tvalid");
        end
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            m_if.tready = pat[6-i];
            @(negedge clk);
            cur = {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser};
            if (stalled) begin
                checks++;
                if (m_if.tvalid !== 1'b1 || cur !== snap) begin
                    failures++;
                    $display("FAIL stall_hold cyc=%0d got=%h want=%h", i, cur, snap);
                end
            end
            if (gnt === 2'b10) begin
                checks++;
                if (s0_if.tvalid !== 1'b1 || s0_if.tready !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_s0_ready cyc=%0d got=v%b/r%b want=v1/r0",
                             i, s0_if.tvalid, s0_if.tready);
                end
            end
            stalled = (m_if.tvalid === 1'b1) && !m_if.tready;
            snap    = cur;
        end
        @(posedge clk); #1;
        m_if.tready = 1'b1;
        drain(30, ok);
        checks++;
        if (!ok || pkt_cnt0 !== CW'(exp_cnt0) || pkt_cnt1 !== CW'(exp_cnt1)) begin
            failures++;
            $display("FAIL stall_cnt got=%0d/%0d drained=%0d want=%0d/%0d",
                     pkt_cnt0, pkt_cnt1, ok, CW'(exp_cnt0), CW'(exp_cnt1));
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] obs;
        logic [5:0] want = 6'b001010;
        int         n;
        bit         ok;
        @(negedge clk); #1;
        push_pkt(0, 1);
        push_pkt(0, 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            obs[5-k] = m_if.tvalid;
        end
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL b2b_gap got=%b want=%b", obs, want);
        end
        drain(20, ok);
        n = (2 ** CW - 1) - (exp_cnt0 % (2 ** CW));
        for (int i = 0; i < n; i++) push_pkt(0, 1);
        drain(n * 3 + 20, ok);
        checks++;
        if (!ok || pkt_cnt0 !== {CW{1'b1}}) begin
            failures++;
            $display("FAIL wrap_max got=%h drained=%0d want=%h", pkt_cnt0, ok, {CW{1'b1}});
        end
        push_pkt(0, 1);
        drain(20, ok);
        checks++;
        if (!ok || pkt_cnt0 !== '0) begin
            failures++;
            $display("FAIL wrap_zero got=%h drained=%0d want=0", pkt_cnt0, ok);
        end
    endtask

    task automatic test_reset_mid_pkt();
        bit ok;
        push_pkt(0, 1);
        drain(20, ok);
        checks++;
        if (!ok || pkt_cnt0 !== 8'd1 || pkt_cnt1 === '0) begin
            failures++;
            $display("FAIL midrst_pre got=%0d/%0d drained=%0d want=1/nonzero", pkt_cnt0, pkt_cnt1, ok);
        end
        push_pkt(0, 3);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 2) begin
                ok = 1'b1;
                break;
            end
        end
        rst_n = 1'b0;
        q0.delete();
        exp_q.delete();
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        @(posedge clk); #1;
        checks++;
        if (!ok || {m_if.tvalid, gnt, s0_if.tready} !== 4'b0 || pkt_cnt0 !== '0 || pkt_cnt1 !== '0) begin
            failures++;
            $display("FAIL midrst_state got=v%b g%b r%b c%0d/%0d beat1=%0d want=v0 g00 r0 c0/0 beat1=1",
                     m_if.tvalid, gnt, s0_if.tready, pkt_cnt0, pkt_cnt1, ok);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        push_pkt(1, 3);
        drain(30, ok);
        checks++;
        if (!ok || pkt_cnt1 !== 8'd1 || pkt_cnt0 !== '0) begin
            failures++;
            $display("FAIL midrst_after got=%0d/%0d drained=%0d want=0/1/1", pkt_cnt0, pkt_cnt1, ok);
        end
    endtask

    initial begin
        m_if.tready = 1'b1;
        test_reset();
        test_single_src();
        test_tie();
        test_stall();
        test_back_to_back();
        test_reset_mid_pkt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
